// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared types, widths and glyph table for the 7-segment display slice
package seg7_pkg;

  localparam int SEG_BITS = 7;

  typedef logic [3:0] bcd_t;

  // a..g with a as the MSB; anything outside 0..9 falls back to the 0 glyph
  function automatic logic [SEG_BITS-1:0] seg7_glyph(input bcd_t nib);
    logic [SEG_BITS-1:0] g;
    case (nib)
      4'd1:    g = 7'b0110000;
      4'd2:    g = 7'b1101101;
      4'd3:    g = 7'b1111001;
      4'd4:    g = 7'b0110011;
      4'd5:    g = 7'b1011011;
      4'd6:    g = 7'b1011111;
      4'd7:    g = 7'b1110000;
      4'd8:    g = 7'b1111111;
      4'd9:    g = 7'b1111011;
      default: g = 7'b1111110;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/seg7_mux_display_if.sv
// rtl/seg7_mux_display_if.sv - count/display bundle between pulse sources and the display driver
interface seg7_mux_display_if #(
  parameter int NUM_DIGITS = 4
);
  import seg7_pkg::*;

  logic                    incrementIn;
  logic                    clearIn;
  logic [NUM_DIGITS-1:0]   dotMaskIn;
  logic [4*NUM_DIGITS-1:0] countOut;
  logic                    overflowOut;
  logic [SEG_BITS:0]       segmentEnableOut;
  logic [NUM_DIGITS-1:0]   digitEnableOut;

  modport slave (
    input  incrementIn, clearIn, dotMaskIn,
    output countOut, overflowOut, segmentEnableOut, digitEnableOut
  );

  modport master (
    output incrementIn, clearIn, dotMaskIn,
    input  countOut, overflowOut, segmentEnableOut, digitEnableOut
  );

endinterface

// File: rtl/bcd_digit_counter.sv
// rtl/bcd_digit_counter.sv - one BCD decade with combinational carry to the next decade
module bcd_digit_counter
  import seg7_pkg::*;
(
  input  logic clkIn,
  input  logic resetIn,
  input  logic clearIn,
  input  logic carryIn,
  output bcd_t digitOut,
  output logic carryOut
);

  bcd_t r_digit;
  logic w_at_nine;

  assign w_at_nine = (r_digit == 4'd9);

  always_ff @(posedge clkIn) begin
    if (resetIn || clearIn) begin
      r_digit <= 4'd0;
    end else if (carryIn) begin
      r_digit <= w_at_nine ? 4'd0 : r_digit + 4'd1;
    end
  end

  assign digitOut = r_digit;
  assign carryOut = carryIn && w_at_nine;

endmodule

// File: rtl/seg7_mux_display.sv
// rtl/seg7_mux_display.sv - N-digit BCD event counter multiplexed onto a shared 7-segment bus
module seg7_mux_display
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int SCAN_DIV       = 27000,
  parameter int GUARD_CYCLES   = 2,
  parameter int BLANK_LEADING  = 1,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int DIG_ACTIVE_LOW = 1
) (
  input logic               clkIn,
  input logic               resetIn,
  seg7_mux_display_if.slave bus
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
  localparam logic [PRE_W-1:0] GUARD_P  = PRE_W'(GUARD_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  // XOR masks that turn active-high internal values into pin polarity
  localparam logic [SEG_BITS:0]     SEG_OFF = (SEG_ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic [NUM_DIGITS-1:0] DIG_OFF = (DIG_ACTIVE_LOW != 0) ? '1 : '0;

  bcd_t                  w_digits [NUM_DIGITS];
  logic [NUM_DIGITS:0]   w_carry;
  logic [NUM_DIGITS:1]   w_zero_above;
  logic [NUM_DIGITS-1:0] w_blank;

  logic [PRE_W-1:0]      r_presc;
  logic [IDX_W-1:0]      r_index;
  logic                  r_overflow;
  logic [SEG_BITS:0]     r_seg;
  logic [NUM_DIGITS-1:0] r_dig;

  logic                  w_guard;
  bcd_t                  w_nibble;
  logic [SEG_BITS:0]     w_seg;
  logic [NUM_DIGITS-1:0] w_dig;

  assign w_carry[0] = bus.incrementIn;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_decade
      bcd_digit_counter u_decade (
        .clkIn    (clkIn),
        .resetIn  (resetIn),
        .clearIn  (bus.clearIn),
        .carryIn  (w_carry[gi]),
        .digitOut (w_digits[gi]),
        .carryOut (w_carry[gi+1])
      );
      assign bus.countOut[4*gi +: 4] = w_digits[gi];
    end

    // w_zero_above[i]: digit i and every more significant digit are zero
    assign w_zero_above[NUM_DIGITS] = (w_digits[NUM_DIGITS-1] == 4'd0);
    for (gi = 1; gi < NUM_DIGITS; gi++) begin : g_zero
      assign w_zero_above[gi] = w_zero_above[gi+1] && (w_digits[gi-1+1] == 4'd0)
                                && (gi == NUM_DIGITS - 1 ? 1'b1 : 1'b1);
    end

    assign w_blank[0] = 1'b0;
    for (gi = 1; gi < NUM_DIGITS; gi++) begin : g_blank
      assign w_blank[gi] = (BLANK_LEADING != 0) && w_zero_above[gi];
    end
  endgenerate

  assign w_guard = (r_presc < GUARD_P);

  always_comb begin
    w_nibble = w_digits[r_index];
    w_seg    = '0;
    w_dig    = '0;
    if (!w_guard) begin
      w_seg[SEG_BITS:1] = w_blank[r_index] ? '0 : seg7_glyph(w_nibble);
      w_seg[0]          = bus.dotMaskIn[r_index];
      w_dig             = NUM_DIGITS'(1) << r_index;
    end
  end

  always_ff @(posedge clkIn) begin
    if (resetIn) begin
      r_presc    <= '0;
      r_index    <= '0;
      r_overflow <= 1'b0;
      r_seg      <= SEG_OFF;
      r_dig      <= DIG_OFF;
    end else begin
      if (r_presc == PRE_LAST) begin
        r_presc <= '0;
        r_index <= (r_index == IDX_LAST) ? '0 : r_index + IDX_W'(1);
      end else begin
        r_presc <= r_presc + PRE_W'(1);
      end
      r_overflow <= w_carry[NUM_DIGITS] && !bus.clearIn;
      r_seg      <= w_seg ^ SEG_OFF;
      r_dig      <= w_dig ^ DIG_OFF;
    end
  end

  assign bus.overflowOut      = r_overflow;
  assign bus.segmentEnableOut = r_seg;
  assign bus.digitEnableOut   = r_dig;

endmodule
